pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline control unit that drives the hold (`*_en`) and bubble-insert (`*_valid`, active-low kill) inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, multi-cycle instruction/data memory stalls, EX-stage control redirects and a retiring halt. It sequences freezes, squashes and bubbles so that no killed instruction writes the register file or data memory.

## Interface
- No parameters.
- `clk` in 1: pipeline clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` in 3: ID-stage source register numbers.
- `id_rs_used`, `id_rt_used` in 1: ID instruction reads that source.
- `ex_rd` in 3: ID/EX destination register.
- `ex_memtoreg` in 1: ID/EX instruction is a load.
- `ex_regwrite` in 1: ID/EX instruction writes a register.
- `ex_redirect` in 1: EX resolved a taken branch or jump.
- `imem_stall`, `imem_done` in 1: fetch busy / fetch data valid. `imem_done` stays asserted until `ifid_en` is sampled high.
- `dmem_stall` in 1: data memory busy; the MEM stage cannot complete.
- `wb_halt` in 1: a valid halt occupies MEM/WB.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: register load enables.
- `ifid_valid`, `idex_valid`, `memwb_valid` out 1: 0 inserts a bubble (clears RegWrite/DMemWrite/DMemEn of the captured slot).
- `imem_cancel` out 1: abort the in-flight fetch.
- `halted` out 1: processor stopped.

## Operation
- States: RUN, ISTALL, DSTALL, HALTED. Flag `squash_pend` (1b). Only state, flag and perf counters are registered. Outputs are combinational from state plus inputs.
- Priority each cycle: reset > HALTED > `dmem_stall` > `ex_redirect` > load-use > `imem_stall` > normal.
- Load-use: `ex_memtoreg & ex_regwrite & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd))`.
- Normal: all enables 1, all valids 1.
- `dmem_stall`:
  - All enables 0, `memwb_en`=1, `memwb_valid`=0. WB drains and no bubble is duplicated.
  - Enter DSTALL; return to RUN the first cycle `dmem_stall`=0.
- `ex_redirect` (not dmem stalled): `pc_en`=1, `ifid_valid`=0, `idex_valid`=0, other enables 1.
  - If state is ISTALL: also `imem_cancel`=1 and set `squash_pend`.
- Load-use: `pc_en`=0, `ifid_en`=0, `idex_valid`=0, other enables 1. This inserts exactly one bubble.
- `imem_stall`: `pc_en`=0, `ifid_valid`=0, downstream enables 1. Enter ISTALL.
- ISTALL to RUN on `imem_done`.
  - If `squash_pend`, that returned word is captured with `ifid_valid`=0 and `squash_pend` clears.
- `wb_halt`=1 in a non-stalled cycle: enter HALTED. In HALTED all enables 0, valids 0, `halted`=1 until reset.
- Reset asserted at any time: state RUN, `squash_pend`=0, counters 0. All enables 0 and all valids 0 while `rst_n`=0.

## Timing
- Hazard response is same-cycle; there is no added latency in RUN.
- Load-use costs 1 cycle.
- Redirect costs 2 slots (IF/ID, ID/EX squashed).
- DSTALL holds for exactly the cycles `dmem_stall`=1.
- First cycle after `rst_n` rises: state RUN, all enables 1, valids 1, unless inputs dictate otherwise.
- `ex_redirect` during DSTALL is ignored until the stall releases. EX is frozen, so the redirect is re-presented.
- Redirect with simultaneous load-use: redirect wins. The hazarding ID instruction is squashed.
- `imem_done` during DSTALL: held (`ifid_en`=0), accepted on release.

## Configuration
- `PIPE_HAZARD_CTRL_PERF_EN` defined: adds outputs `perf_lu_cnt`, `perf_istall_cnt`, `perf_dstall_cnt`, `perf_flush_cnt` (16b each).
  - Each is a saturating count at 0xFFFF of the cycles the corresponding condition won priority.
  - All cleared by reset; frozen in HALTED.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

## Structure
- The shared pipeline package holds the state enum (RUN=0, ISTALL=1, DSTALL=2, HALTED=3) and the register-number width constant (3).
- One sub-module: `hazard_detect` (pure combinational load-use compare).

## Test plan
- Load r3 into ID/EX (`ex_rd`=3, `ex_memtoreg`=1), ID `id_rs`=3 used -> one cycle `pc_en`=0, `ifid_en`=0, `idex_valid`=0, then normal.
- `dmem_stall` high 4 cycles -> 4 cycles all enables 0 except `memwb_en`=1 with `memwb_valid`=0; RUN on cycle 5.
- `imem_stall` 3 cycles, `ex_redirect` on cycle 2 -> `imem_cancel`=1 that cycle; the word returned with `imem_done` is captured with `ifid_valid`=0.
- `ex_redirect` and load-use same cycle -> `pc_en`=1, `ifid_valid`=0, `idex_valid`=0, no load-use stall.
- `wb_halt`=1 -> next cycle `halted`=1, all enables 0; `rst_n` low mid-HALTED -> RUN after release.
- With `PIPE_HAZARD_CTRL_PERF_EN`: 70000 DSTALL cycles -> `perf_dstall_cnt`=0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control types: controller states, register-number width
// and a saturating increment used by the optional performance counters.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ISTALL = 2'd1,
        DSTALL = 2'd2,
        HALTED = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard sources from the datapath and the pipeline-register controls
// returned to it; master is the control unit, slave the datapath.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memtoreg;
    logic             ex_regwrite;
    logic             ex_redirect;
    logic             imem_stall;
    logic             imem_done;
    logic             dmem_stall;
    logic             wb_halt;

    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_valid;
    logic idex_valid;
    logic memwb_valid;
    logic imem_cancel;
    logic halted;

    modport master (
        input  id_rs, id_rt, id_rs_used, id_rt_used,
        input  ex_rd, ex_memtoreg, ex_regwrite, ex_redirect,
        input  imem_stall, imem_done, dmem_stall, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_valid, idex_valid, memwb_valid,
        output imem_cancel, halted
    );

    modport slave (
        output id_rs, id_rt, id_rs_used, id_rt_used,
        output ex_rd, ex_memtoreg, ex_regwrite, ex_redirect,
        output imem_stall, imem_done, dmem_stall, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_valid, idex_valid, memwb_valid,
        input  imem_cancel, halted
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare: the ID instruction reads a register that the load
// currently in EX has not produced yet.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic [REG_W-1:0] rd,
    input  logic             memtoreg,
    input  logic             regwrite,
    output logic             hazard
);

    assign hazard = memtoreg & regwrite &
                    ((rs_used & (rs == rd)) |
                     (rt_used & (rt == rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/bubble sequencer for load-use, I/D memory stalls, redirects
// and halt. Optional perf counters under PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    pipe_hazard_ctrl_if.master bus
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0] perf_lu_cnt,
    output logic [15:0] perf_istall_cnt,
    output logic [15:0] perf_dstall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    state_t state;
    state_t state_nx;
    logic   squash_pend;
    logic   squash_nx;
    logic   load_use;

    hazard_detect u_hd (
        .rs       (bus.id_rs),
        .rt       (bus.id_rt),
        .rs_used  (bus.id_rs_used),
        .rt_used  (bus.id_rt_used),
        .rd       (bus.ex_rd),
        .memtoreg (bus.ex_memtoreg),
        .regwrite (bus.ex_regwrite),
        .hazard   (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            squash_pend <= 1'b0;
        end else begin
            state       <= state_nx;
            squash_pend <= squash_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        squash_nx       = squash_pend;
        bus.pc_en       = 1'b0;
        bus.ifid_en     = 1'b0;
        bus.idex_en     = 1'b0;
        bus.exmem_en    = 1'b0;
        bus.memwb_en    = 1'b0;
        bus.ifid_valid  = 1'b0;
        bus.idex_valid  = 1'b0;
        bus.memwb_valid = 1'b0;
        bus.imem_cancel = 1'b0;
        bus.halted      = 1'b0;
        if (rst_n) begin
            if (state == HALTED) begin
                bus.halted = 1'b1;
            end else if (bus.dmem_stall) begin
                // Everything upstream holds; WB drains into a bubble.
                bus.memwb_en   = 1'b1;
                bus.ifid_valid = 1'b1;
                bus.idex_valid = 1'b1;
                state_nx       = DSTALL;
            end else begin
                bus.pc_en       = 1'b1;
                bus.ifid_en     = 1'b1;
                bus.idex_en     = 1'b1;
                bus.exmem_en    = 1'b1;
                bus.memwb_en    = 1'b1;
                bus.ifid_valid  = 1'b1;
                bus.idex_valid  = 1'b1;
                bus.memwb_valid = 1'b1;
                state_nx = bus.imem_stall ? ISTALL : RUN;
                // Word from a cancelled fetch enters IF/ID as a bubble.
                if (squash_pend && bus.imem_done) begin
                    bus.ifid_valid = 1'b0;
                    squash_nx      = 1'b0;
                end
                if (bus.ex_redirect) begin
                    bus.ifid_valid = 1'b0;
                    bus.idex_valid = 1'b0;
                    if (state == ISTALL) begin
                        bus.imem_cancel = 1'b1;
                        squash_nx       = 1'b1;
                    end
                end else if (load_use) begin
                    bus.pc_en      = 1'b0;
                    bus.ifid_en    = 1'b0;
                    bus.idex_valid = 1'b0;
                    squash_nx      = squash_pend;
                end else if (bus.imem_stall) begin
                    bus.pc_en      = 1'b0;
                    bus.ifid_valid = 1'b0;
                end
                if (bus.wb_halt) begin
                    state_nx = HALTED;
                end
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic active;
    logic dst_win;
    logic flush_win;
    logic lu_win;
    logic ist_win;

    assign active    = (state != HALTED);
    assign dst_win   = active & bus.dmem_stall;
    assign flush_win = active & ~bus.dmem_stall & bus.ex_redirect;
    assign lu_win    = active & ~bus.dmem_stall & ~bus.ex_redirect
                     & load_use;
    assign ist_win   = active & ~bus.dmem_stall & ~bus.ex_redirect
                     & ~load_use & bus.imem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_cnt     <= 16'd0;
            perf_istall_cnt <= 16'd0;
            perf_dstall_cnt <= 16'd0;
            perf_flush_cnt  <= 16'd0;
        end else begin
            if (lu_win)    perf_lu_cnt     <= sat_inc(perf_lu_cnt);
            if (ist_win)   perf_istall_cnt <= sat_inc(perf_istall_cnt);
            if (dst_win)   perf_dstall_cnt <= sat_inc(perf_dstall_cnt);
            if (flush_win) perf_flush_cnt  <= sat_inc(perf_flush_cnt);
        end
    end
`endif

endmodule
